// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and defaults for the data-memory arbiter
package dmem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_CPU = 2'd1;
    localparam logic [1:0] RD_DBG = 2'd2;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/starve_cnt.sv
// rtl/starve_cnt.sv - saturating count of CPU grants made while the debug port waits
module starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         saturated
);

    localparam logic [W-1:0] MAX = W'(LIMIT);

    // clear wins over increment; the count holds once it reaches the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

    assign saturated = (count == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (CPU/debug) arbiter in front of a single-port synchronous data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             in_idle;
    logic             grant_cpu;
    logic             grant_dbg;
    logic             saturated;
    logic [CNT_W-1:0] starve_count;

    starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc       (grant_cpu & dbg_req),
        .clr       (grant_dbg),
        .count     (starve_count),
        .saturated (saturated)
    );

    // grants are only made from IDLE; reset is folded in so every output reads 0 while it is held
    always_comb begin
        in_idle   = ~reset & (state == IDLE);
        grant_dbg = in_idle & dbg_req & (~cpu_req | saturated);
        grant_cpu = in_idle & cpu_req & ~grant_dbg;
        state_nxt = IDLE;
        if (grant_cpu && !cpu_we) begin
            state_nxt = RD_CPU;
        end else if (grant_dbg && !dbg_we) begin
            state_nxt = RD_DBG;
        end
    end

    // state register; a read in flight at reset is simply forgotten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // memory strobe is issued combinationally in the grant cycle
    always_comb begin
        mem_en    = grant_cpu | grant_dbg;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_dbg) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // stores complete in the issue cycle, loads in the RD_* cycle with the memory's registered data
    always_comb begin
        cpu_ready = (grant_cpu & cpu_we) | (state == RD_CPU);
        dbg_ready = (grant_dbg & dbg_we) | (state == RD_DBG);
        cpu_rdata = (state == RD_CPU) ? mem_rdata : '0;
        dbg_rdata = (state == RD_DBG) ? mem_rdata : '0;
        cpu_stall = ~reset & cpu_req & ~cpu_ready;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ready, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ready;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    int checks;
    int errors;
    int cpu_done;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ready (dbg_ready),
        .dbg_rdata (dbg_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port memory model
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        int n;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready) break;
            n++;
            if (n > 30) begin
                checks++; errors++;
                $display("FAIL cpu_op_timeout addr=%h", addr);
                break;
            end
        end
        rdata = cpu_rdata;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        int n;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        n = 0;
        forever begin
            @(negedge clk);
            if (dbg_ready) break;
            n++;
            if (n > 30) begin
                checks++; errors++;
                $display("FAIL dbg_op_timeout addr=%h", addr);
                break;
            end
        end
        rdata = dbg_rdata;
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4; cpu_wdata = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'h1;
        #3;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
        checks++; if ({cpu_ready, dbg_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {cpu_ready, dbg_ready}); end
        checks++; if (dut.u_starve.count !== 3'd0) begin errors++; $display("FAIL reset_starve got=%0d exp=0", dut.u_starve.count); end
        @(posedge clk); #1;
        reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        mem[0] = 32'h2A;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        @(negedge clk);
        checks++; if ({mem_en, mem_we, cpu_stall, cpu_ready} !== 4'b1010) begin errors++; $display("FAIL rd_issue en/we/stall/ready got=%b exp=1010", {mem_en, mem_we, cpu_stall, cpu_ready}); end
        @(negedge clk);
        checks++; if ({mem_en, cpu_stall, cpu_ready} !== 3'b001) begin errors++; $display("FAIL rd_data en/stall/ready got=%b exp=001", {mem_en, cpu_stall, cpu_ready}); end
        checks++; if (cpu_rdata !== 32'h2A) begin errors++; $display("FAIL rd_data got=%h exp=0000002a", cpu_rdata); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_en, cpu_ready, cpu_rdata} !== 34'h0) begin errors++; $display("FAIL rd_idle en/ready/rdata nonzero got=%b/%b/%h", mem_en, cpu_ready, cpu_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_write();
        logic [31:0] r;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h5;
        @(negedge clk);
        checks++; if ({mem_en, mem_we, cpu_ready, cpu_stall} !== 4'b1110) begin errors++; $display("FAIL wr_issue en/we/ready/stall got=%b exp=1110", {mem_en, mem_we, cpu_ready, cpu_stall}); end
        checks++; if (mem_wdata !== 32'h5 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL wr_data wdata=%h rdata=%h exp=5/0", mem_wdata, cpu_rdata); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_addr = 32'h3; cpu_we = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h3) begin errors++; $display("FAIL misaligned_addr got=%h exp=00000003", mem_addr); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        cpu_op(1'b0, 32'h0, 32'h0, r);
        checks++; if (r !== 32'h5) begin errors++; $display("FAIL wr_readback got=%h exp=00000005", r); end
    endtask

    task automatic test_starvation();
        logic [31:0] dr;
        int done_at_dbg;
        logic [3:0] cnt_after;
        for (int i = 0; i < 6; i++) mem[8 + i] = 32'h100 + i;
        mem[4] = 32'hDEADBEEF;
        cpu_done = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [31:0] r;
                    cpu_op(1'b0, 32'h20 + 4 * i, 32'h0, r);
                    checks++; if (r !== 32'h100 + i) begin errors++; $display("FAIL starve_cpu_load%0d got=%h exp=%h", i, r, 32'h100 + i); end
                    cpu_done++;
                end
            end
            begin
                dbg_op(1'b0, 32'h10, 32'h0, dr);
                done_at_dbg = cpu_done;
                cnt_after = 4'(dut.u_starve.count);
            end
        join
        checks++; if (dr !== 32'hDEADBEEF) begin errors++; $display("FAIL starve_dbg_rdata got=%h exp=deadbeef", dr); end
        checks++; if (done_at_dbg !== 4) begin errors++; $display("FAIL starve_cpu_grants got=%0d exp=4", done_at_dbg); end
        checks++; if (cnt_after !== 4'd0) begin errors++; $display("FAIL starve_count_clear got=%0d exp=0", cnt_after); end
    endtask

    task automatic test_simul_store();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h11;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'h22;
        @(negedge clk);
        checks++; if ({cpu_ready, dbg_ready} !== 2'b10 || mem_addr !== 32'h40) begin errors++; $display("FAIL simul_first ready=%b addr=%h exp=10/40", {cpu_ready, dbg_ready}, mem_addr); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if ({cpu_ready, dbg_ready} !== 2'b01 || mem_addr !== 32'h44) begin errors++; $display("FAIL simul_second ready=%b addr=%h exp=01/44", {cpu_ready, dbg_ready}, mem_addr); end
        @(posedge clk); #1;
        dbg_req = 1'b0;
        checks++; if (mem[16] !== 32'h11 || mem[17] !== 32'h22) begin errors++; $display("FAIL simul_mem got=%h/%h exp=11/22", mem[16], mem[17]); end
        checks++; if (dut.u_starve.count !== 3'd0) begin errors++; $display("FAIL simul_starve got=%0d exp=0", dut.u_starve.count); end
    endtask

    task automatic test_reset_in_read();
        logic [31:0] r;
        int seen;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        @(posedge clk); #1;
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_pre ready got=%b exp=1", cpu_ready); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({cpu_ready, mem_en, cpu_stall, cpu_rdata} !== 35'h0) begin errors++; $display("FAIL rst_rd_outputs ready=%b en=%b stall=%b rdata=%h exp=0", cpu_ready, mem_en, cpu_stall, cpu_rdata); end
        @(posedge clk); #1;
        reset = 1'b0; cpu_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ready) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_rd_orphan_ready got=%0d exp=0", seen); end
        @(posedge clk); #1;
        cpu_op(1'b0, 32'h0, 32'h0, r);
        checks++; if (r !== 32'h5) begin errors++; $display("FAIL rst_rd_after got=%h exp=00000005", r); end
    endtask

    task automatic test_program();
        logic [31:0] x4;
        fork
            begin
                logic [31:0] d;
                cpu_op(1'b1, 32'h80, 32'h1, d);
                cpu_op(1'b1, 32'h84, 32'h2, d);
                cpu_op(1'b1, 32'h88, 32'h3, d);
                cpu_op(1'b0, 32'h84, 32'h0, x4);
            end
            begin
                logic [31:0] d;
                for (int i = 0; i < 4; i++) dbg_op(1'b1, 32'h100 + 4 * i, 32'hA0 + i, d);
            end
        join
        checks++; if (x4 !== 32'h2) begin errors++; $display("FAIL prog_x4 got=%h exp=00000002", x4); end
        checks++; if (mem[32] !== 32'h1 || mem[33] !== 32'h2 || mem[34] !== 32'h3) begin errors++; $display("FAIL prog_cpu_stores got=%h/%h/%h exp=1/2/3", mem[32], mem[33], mem[34]); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[64 + i] !== 32'hA0 + i) begin errors++; $display("FAIL prog_dbg_store%0d got=%h exp=%h", i, mem[64 + i], 32'hA0 + i); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem_rdata = 32'h0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_starvation();
        test_simul_store();
        test_reset_in_read();
        test_program();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
